// File: rtl/hyperbus_delay_pkg.sv
// Shared types and widths for the HyperBus delay-line controller.
// Holds the FSM state encoding and the helper that picks the centre tap of a window.
package hyperbus_delay_pkg;

    localparam int NumTaps = 16;
    localparam int DelayW  = $clog2(NumTaps);
    localparam int WinW    = $clog2(NumTaps + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_PROBE,
        ST_FINAL_APPLY,
        ST_FINAL_SETTLE
    } state_t;

    // Centre of a window, rounding toward the start tap for even lengths.
    function automatic logic [DelayW-1:0] centre_tap(
        input logic [DelayW-1:0] start,
        input logic [WinW-1:0]   len
    );
        return DelayW'({1'b0, start} + ((len - WinW'(1)) >> 1));
    endfunction

endpackage

// File: rtl/hyperbus_delay_window.sv
// Tracks runs of passing probes across a tap sweep and keeps the longest one.
// Tap position is counted internally: one step per valid sample, restarted by clear.
module hyperbus_delay_window
    import hyperbus_delay_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear,
    input  logic              valid,
    input  logic              pass,
    input  logic              last,
    output logic [DelayW-1:0] best_start,
    output logic [WinW-1:0]   best_len
);

    logic [DelayW-1:0] idx_reg;
    logic [DelayW-1:0] cur_start_reg;
    logic [WinW-1:0]   cur_len_reg;
    logic [DelayW-1:0] best_start_reg;
    logic [WinW-1:0]   best_len_reg;

    logic [DelayW-1:0] run_start;
    logic [WinW-1:0]   ext_len;
    logic              close_run;
    logic [DelayW-1:0] close_start;
    logic [WinW-1:0]   close_len;

    always_comb begin
        run_start   = (cur_len_reg == '0) ? idx_reg : cur_start_reg;
        ext_len     = cur_len_reg + WinW'(1);
        // A fail ends the run before this tap; the final tap ends the run including it.
        close_run   = valid && (!pass || last);
        close_start = pass ? run_start : cur_start_reg;
        close_len   = pass ? ext_len : cur_len_reg;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_reg        <= '0;
            cur_start_reg  <= '0;
            cur_len_reg    <= '0;
            best_start_reg <= '0;
            best_len_reg   <= '0;
        end else if (clear) begin
            idx_reg        <= '0;
            cur_start_reg  <= '0;
            cur_len_reg    <= '0;
            best_start_reg <= '0;
            best_len_reg   <= '0;
        end else if (valid) begin
            idx_reg <= idx_reg + DelayW'(1);
            if (pass) begin
                cur_start_reg <= run_start;
                cur_len_reg   <= ext_len;
            end else begin
                cur_len_reg   <= '0;
            end
            // Strictly longer only, so the earliest window wins a tie.
            if (close_run && (close_len > best_len_reg)) begin
                best_start_reg <= close_start;
                best_len_reg   <= close_len;
            end
        end
    end

    assign best_start = best_start_reg;
    assign best_len   = best_len_reg;

endmodule

// File: rtl/hyperbus_delay_ctrl.sv
// Tap controller for the HyperBus RWDS/clock delay line: direct writes plus a
// 16-tap calibration sweep that settles on the centre of the longest passing window.
module hyperbus_delay_ctrl
    import hyperbus_delay_pkg::*;
#(
    parameter int                SettleCycles = 4,
    parameter logic [DelayW-1:0] DefaultDelay = 4'd8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic              cfg_cal_i,
    input  logic [DelayW-1:0] cfg_delay_i,
    input  logic              phy_idle_i,
    output logic [DelayW-1:0] delay_o,
    output logic              probe_req_o,
    input  logic              probe_ack_i,
    input  logic              probe_pass_i,
    output logic              busy_o,
    output logic              cal_done_o,
    output logic              cal_fail_o,
    output logic [WinW-1:0]   cal_window_o
);

    localparam int CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam logic [CntW-1:0]   SettleLoad = CntW'(SettleCycles - 1);
    localparam logic [DelayW-1:0] LastTap    = DelayW'(NumTaps - 1);

    state_t            state_reg, state_next;
    logic [DelayW-1:0] delay_reg;
    logic [DelayW-1:0] wr_delay_reg;
    logic [DelayW-1:0] saved_delay_reg;
    logic [DelayW-1:0] tap_reg;
    logic [CntW-1:0]   settle_cnt_reg;
    logic              cal_mode_reg;
    logic              cal_fail_reg;
    logic [WinW-1:0]   cal_window_reg;

    logic              accept;
    logic              track_clear;
    logic              track_valid;
    logic              settle_done;
    logic [DelayW-1:0] best_start;
    logic [WinW-1:0]   best_len;
    logic [DelayW-1:0] final_target;

    hyperbus_delay_window u_window (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear      (track_clear),
        .valid      (track_valid),
        .pass       (probe_pass_i),
        .last       (tap_reg == LastTap),
        .best_start (best_start),
        .best_len   (best_len)
    );

    always_comb begin
        state_next   = state_reg;
        accept       = 1'b0;
        track_clear  = 1'b0;
        track_valid  = 1'b0;
        settle_done  = (settle_cnt_reg == '0);
        cfg_ready_o  = (state_reg == ST_IDLE);
        busy_o       = (state_reg != ST_IDLE);
        probe_req_o  = (state_reg == ST_PROBE);
        cal_done_o   = (state_reg == ST_FINAL_SETTLE) && settle_done;
        final_target = (best_len != '0) ? centre_tap(best_start, best_len) : saved_delay_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cfg_valid_i) begin
                    accept      = 1'b1;
                    track_clear = cfg_cal_i;
                    state_next  = ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (phy_idle_i) state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_done) state_next = cal_mode_reg ? ST_PROBE : ST_IDLE;
            end
            ST_PROBE: begin
                if (probe_ack_i) begin
                    track_valid = 1'b1;
                    state_next  = (tap_reg == LastTap) ? ST_FINAL_APPLY : ST_APPLY;
                end
            end
            ST_FINAL_APPLY: begin
                if (phy_idle_i) state_next = ST_FINAL_SETTLE;
            end
            ST_FINAL_SETTLE: begin
                if (settle_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            delay_reg       <= DefaultDelay;
            wr_delay_reg    <= '0;
            saved_delay_reg <= '0;
            tap_reg         <= '0;
            settle_cnt_reg  <= '0;
            cal_mode_reg    <= 1'b0;
            cal_fail_reg    <= 1'b0;
            cal_window_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        cal_mode_reg <= cfg_cal_i;
                        wr_delay_reg <= cfg_delay_i;
                        if (cfg_cal_i) begin
                            tap_reg         <= '0;
                            saved_delay_reg <= delay_reg;
                            cal_fail_reg    <= 1'b0;
                        end
                    end
                end
                ST_APPLY: begin
                    if (phy_idle_i) begin
                        delay_reg      <= cal_mode_reg ? tap_reg : wr_delay_reg;
                        settle_cnt_reg <= SettleLoad;
                    end
                end
                ST_PROBE: begin
                    if (probe_ack_i && (tap_reg != LastTap)) tap_reg <= tap_reg + DelayW'(1);
                end
                ST_FINAL_APPLY: begin
                    // Results are published together with the final tap so they are
                    // stable for the whole settle interval, including the done pulse.
                    if (phy_idle_i) begin
                        delay_reg      <= final_target;
                        settle_cnt_reg <= SettleLoad;
                        cal_window_reg <= best_len;
                        cal_fail_reg   <= (best_len == '0);
                    end
                end
                ST_SETTLE, ST_FINAL_SETTLE: begin
                    if (!settle_done) settle_cnt_reg <= settle_cnt_reg - CntW'(1);
                end
                default: ;
            endcase
        end
    end

    assign delay_o      = delay_reg;
    assign cal_fail_o   = cal_fail_reg;
    assign cal_window_o = cal_window_reg;

endmodule

// File: tb/tb_hyperbus_delay_ctrl.sv
// Scoreboard bench for hyperbus_delay_ctrl: stimulus pushes expected results,
// a monitor compares them whenever the controller returns from busy to idle.
module tb_hyperbus_delay_ctrl;

    localparam int S       = 4;
    localparam int CalCyc  = 16 * (S + 2) + S + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic       cfg_cal = 1'b0;
    logic [3:0] cfg_delay = 4'd0;
    logic       phy_idle = 1'b1;
    logic [3:0] delay_o;
    logic       probe_req;
    logic       probe_ack = 1'b0;
    logic       probe_pass = 1'b0;
    logic       busy;
    logic       cal_done;
    logic       cal_fail;
    logic [4:0] cal_window;

    hyperbus_delay_ctrl #(.SettleCycles(S), .DefaultDelay(4'd8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_cal_i    (cfg_cal),
        .cfg_delay_i  (cfg_delay),
        .phy_idle_i   (phy_idle),
        .delay_o      (delay_o),
        .probe_req_o  (probe_req),
        .probe_ack_i  (probe_ack),
        .probe_pass_i (probe_pass),
        .busy_o       (busy),
        .cal_done_o   (cal_done),
        .cal_fail_o   (cal_fail),
        .cal_window_o (cal_window)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic [4:0] w;
        logic       f;
        logic       cal;
        string      name;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    logic [15:0] pass_mask = 16'h0000;
    logic       stall_en = 1'b0;
    logic [3:0] stall_tap = 4'd0;
    logic [4:0] last_win = 5'd0;
    logic       last_fail = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic sb_push(input logic [3:0] d, input logic [4:0] w, input logic f,
                           input logic cal, input string name);
        exp_t e;
        e.d = d; e.w = w; e.f = f; e.cal = cal; e.name = name;
        sb.push_back(e);
    endtask

    // Probe responder: acks in the cycle the request is first seen, unless stalled.
    always @(negedge clk) begin
        if (probe_req && !(stall_en && delay_o == stall_tap)) begin
            probe_ack  = 1'b1;
            probe_pass = pass_mask[delay_o];
        end else begin
            probe_ack  = 1'b0;
            probe_pass = 1'b0;
        end
    end

    // Monitor: a busy->idle transition marks a completed transaction.
    logic prev_busy = 1'b0;
    int   done_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_busy = 1'b0;
            done_cnt  = 0;
        end else begin
            if (cal_done) done_cnt++;
            if (prev_busy && !busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_delay"}, delay_o, e.d);
                    chk({e.name, "_window"}, cal_window, e.w);
                    chk({e.name, "_fail"}, cal_fail, e.f);
                    chk({e.name, "_done_pulses"}, done_cnt, e.cal ? 1 : 0);
                end
                done_cnt = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic write_direct(input logic [3:0] d, input int nlow, input string name);
        logic [3:0] old;
        old = delay_o;
        sb_push(d, last_win, last_fail, 1'b0, name);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_cal = 1'b0; cfg_delay = d; phy_idle = (nlow == 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int i = 0; i < nlow; i++) begin
            chk({name, "_hold_while_busy_phy"}, delay_o, old);
            if (i < nlow - 1) @(negedge clk);
        end
        phy_idle = 1'b1;
        @(negedge clk);
        chk({name, "_applied"}, delay_o, d);
        chk({name, "_ready_low_settle0"}, cfg_ready, 0);
        for (int i = 1; i < S; i++) begin
            @(negedge clk);
            chk({name, "_ready_low_settle"}, cfg_ready, 0);
        end
        @(negedge clk);
        chk({name, "_ready_back"}, cfg_ready, 1);
    endtask

    task automatic run_cal(input logic [15:0] mask, input logic [3:0] e_d,
                           input logic [4:0] e_w, input logic e_f, input string name);
        int n;
        pass_mask = mask;
        sb_push(e_d, e_w, e_f, 1'b1, name);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_cal = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0; cfg_cal = 1'b0;
        chk({name, "_fail_cleared"}, cal_fail, 0);
        n = 0;
        while (busy && n < 400) begin
            n++;
            if (n == 20) begin cfg_valid = 1'b1; cfg_delay = 4'd1; end
            if (n == 25) chk({name, "_ready_low_busy"}, cfg_ready, 0);
            if (n == 30) cfg_valid = 1'b0;
            @(negedge clk);
        end
        chk({name, "_cycles"}, n, CalCyc);
        last_win  = e_w;
        last_fail = e_f;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_delay", delay_o, 8);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_probe", probe_req, 0);
        chk("rst_done", cal_done, 0);
        chk("rst_fail", cal_fail, 0);
        chk("rst_window", cal_window, 0);

        write_direct(4'd3, 5, "wr3");
        run_cal(16'h03F8, 4'd6, 5'd7, 1'b0, "cal_3to9");
        run_cal(16'hFFFF, 4'd7, 5'd16, 1'b0, "cal_all");
        run_cal(16'h8000, 4'd15, 5'd1, 1'b0, "cal_tap15");
        run_cal(16'h1C0E, 4'd2, 5'd3, 1'b0, "cal_tie");
        write_direct(4'd5, 0, "wr5");
        run_cal(16'h0000, 4'd5, 5'd0, 1'b1, "cal_none");
        run_cal(16'h03F8, 4'd6, 5'd7, 1'b0, "cal_recover");

        // Reset while the probe at tap 9 is outstanding.
        pass_mask = 16'hFFFF;
        stall_tap = 4'd9;
        stall_en  = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_cal = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0; cfg_cal = 1'b0;
        n = 0;
        while (!(probe_req && delay_o == 4'd9) && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("rstprobe_reached_tap9", (n < 300) ? 1 : 0, 1);
        #1 rst = 1'b1;
        #1;
        chk("rstprobe_req_drop", probe_req, 0);
        chk("rstprobe_delay", delay_o, 8);
        chk("rstprobe_ready", cfg_ready, 1);
        chk("rstprobe_busy", busy, 0);
        chk("rstprobe_window", cal_window, 0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        stall_en = 1'b0;

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
